// File: rtl/weights_clauses_stream_loader.sv
// -----------------------------------------------------------------------------
// weights_clauses_stream_loader
//
// Upstream feeder for the weight/clauses SRAM write glue. Accepts a 32-bit
// valid/ready word stream and packs every WORDS_PER_LINE consecutive words into
// one SRAM line. For each completed line it presents the absolute glue address,
// the packed data words and a single-cycle write strobe for the selected region.
// The line address auto-increments over the programmed range.
//
// Ports:
//   i_clk, i_rst          clock (rising edge) and synchronous active-high reset
//   i_start               one-cycle launch pulse, honoured only when idle
//   i_target_sel          0 = weight region, 1 = clauses region (sampled at start)
//   i_start_line          region-local first line (sampled at start)
//   i_num_lines           number of lines to load (sampled at start)
//   i_abort               abandons a load that is filling or writing
//   i_s_valid/i_s_data    input word stream, o_s_ready is its ready
//   o_addr_reg            absolute line address to the glue (registered, held)
//   o_weight_data0..7     packed line, data0 = first word received (held)
//   o_cmd_weight_write    one-cycle write strobe for the weight region
//   o_cmd_Clauses_write   one-cycle write strobe for the clauses region
//   o_cmd_weight_read     tied low
//   o_cmd_Clauses_read    tied low
//   o_busy                high whenever the loader is not idle
//   o_done                one-cycle completion pulse (not raised on abort)
//   o_error               sticky range error, cleared by the next accepted start
//   o_lines_written       lines committed in the current or last load
// -----------------------------------------------------------------------------
module weights_clauses_stream_loader #(
  parameter int ADDR_WIDTH        = 11,
  parameter int WORD_WIDTH        = 32,
  parameter int WORDS_PER_LINE    = 8,
  parameter int CLAUSES_BASE_ADDR = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_target_sel,
  input  logic [ADDR_WIDTH-1:0] i_start_line,
  input  logic [ADDR_WIDTH:0]   i_num_lines,
  input  logic                  i_abort,
  input  logic                  i_s_valid,
  input  logic [WORD_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic [ADDR_WIDTH-1:0] o_addr_reg,
  output logic [WORD_WIDTH-1:0] o_weight_data0,
  output logic [WORD_WIDTH-1:0] o_weight_data1,
  output logic [WORD_WIDTH-1:0] o_weight_data2,
  output logic [WORD_WIDTH-1:0] o_weight_data3,
  output logic [WORD_WIDTH-1:0] o_weight_data4,
  output logic [WORD_WIDTH-1:0] o_weight_data5,
  output logic [WORD_WIDTH-1:0] o_weight_data6,
  output logic [WORD_WIDTH-1:0] o_weight_data7,
  output logic                  o_cmd_weight_write,
  output logic                  o_cmd_Clauses_write,
  output logic                  o_cmd_weight_read,
  output logic                  o_cmd_Clauses_read,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_lines_written
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int CNT_W = ADDR_WIDTH + 1;
  // Range sums use two extra bits so start_line + num_lines + base cannot wrap.
  localparam int EXT_W = ADDR_WIDTH + 2;

  localparam logic [EXT_W-1:0]      BASE_EXT  = EXT_W'(CLAUSES_BASE_ADDR);
  localparam logic [EXT_W-1:0]      SPAN_EXT  = {2'b01, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(CLAUSES_BASE_ADDR);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q,         state_d;
  logic                    target_q,        target_d;
  logic [ADDR_WIDTH-1:0]   start_line_q,    start_line_d;
  logic [CNT_W-1:0]        num_lines_q,     num_lines_d;
  logic [CNT_W-1:0]        line_ofs_q,      line_ofs_d;
  logic [CNT_W-1:0]        lines_written_q, lines_written_d;
  logic [IDX_W-1:0]        word_idx_q,      word_idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q,          addr_d;
  logic [WORD_WIDTH-1:0]   data_q [WORDS_PER_LINE];
  logic [WORD_WIDTH-1:0]   data_d [WORDS_PER_LINE];
  logic                    cmd_w_q,         cmd_w_d;
  logic                    cmd_c_q,         cmd_c_d;
  logic                    done_q,          done_d;
  logic                    error_q,         error_d;

  logic [EXT_W-1:0]        req_sum_s;
  logic                    range_fail_s;
  logic                    last_line_s;

  // Range check of the requested load against the selected region.
  always_comb begin
    req_sum_s = {2'b00, i_start_line} + {1'b0, i_num_lines};
    if (i_target_sel) begin
      range_fail_s = ((BASE_EXT + req_sum_s) > SPAN_EXT);
    end else begin
      range_fail_s = (req_sum_s > BASE_EXT);
    end
  end

  // The line being written now is the final one of the load.
  always_comb begin
    last_line_s = ((lines_written_q + CNT_W'(1)) == num_lines_q);
  end

  // Next-state, datapath and strobe computation.
  always_comb begin
    state_d         = state_q;
    target_d        = target_q;
    start_line_d    = start_line_q;
    num_lines_d     = num_lines_q;
    line_ofs_d      = line_ofs_q;
    lines_written_d = lines_written_q;
    word_idx_d      = word_idx_q;
    addr_d          = addr_q;
    data_d          = data_q;
    error_d         = error_q;
    cmd_w_d         = 1'b0;
    cmd_c_d         = 1'b0;
    done_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          target_d        = i_target_sel;
          start_line_d    = i_start_line;
          num_lines_d     = i_num_lines;
          line_ofs_d      = {CNT_W{1'b0}};
          lines_written_d = {CNT_W{1'b0}};
          word_idx_d      = {IDX_W{1'b0}};
          error_d         = range_fail_s;
          if (range_fail_s || (i_num_lines == {CNT_W{1'b0}})) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        // Abort wins over any handshake in the same cycle; the partial line
        // is simply forgotten by rewinding the word index.
        if (i_abort) begin
          state_d    = S_IDLE;
          word_idx_d = {IDX_W{1'b0}};
        end else if (i_s_valid) begin
          data_d[word_idx_q] = i_s_data;
          if (word_idx_q == LAST_IDX) begin
            // Address and strobe are registered here so they appear together
            // with the completed line in the WRITE cycle.
            word_idx_d = {IDX_W{1'b0}};
            state_d    = S_WRITE;
            addr_d     = (target_q ? BASE_ADDR : {ADDR_WIDTH{1'b0}})
                         + start_line_q + line_ofs_q[ADDR_WIDTH-1:0];
            cmd_w_d    = ~target_q;
            cmd_c_d    = target_q;
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
          end
        end else begin
          word_idx_d = word_idx_q;
        end
      end

      S_WRITE: begin
        // The strobe already on the bus completes, so the line counts as
        // committed even if an abort arrives in this cycle.
        line_ofs_d      = line_ofs_q + CNT_W'(1);
        lines_written_d = lines_written_q + CNT_W'(1);
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (last_line_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        word_idx_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      target_q        <= 1'b0;
      start_line_q    <= {ADDR_WIDTH{1'b0}};
      num_lines_q     <= {CNT_W{1'b0}};
      line_ofs_q      <= {CNT_W{1'b0}};
      lines_written_q <= {CNT_W{1'b0}};
      word_idx_q      <= {IDX_W{1'b0}};
      addr_q          <= {ADDR_WIDTH{1'b0}};
      cmd_w_q         <= 1'b0;
      cmd_c_q         <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        data_q[k] <= {WORD_WIDTH{1'b0}};
      end
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      start_line_q    <= start_line_d;
      num_lines_q     <= num_lines_d;
      line_ofs_q      <= line_ofs_d;
      lines_written_q <= lines_written_d;
      word_idx_q      <= word_idx_d;
      addr_q          <= addr_d;
      cmd_w_q         <= cmd_w_d;
      cmd_c_q         <= cmd_c_d;
      done_q          <= done_d;
      error_q         <= error_d;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Output mapping; ready and busy are direct decodes of the state register.
  always_comb begin
    o_s_ready           = (state_q == S_FILL);
    o_busy              = (state_q != S_IDLE);
    o_addr_reg          = addr_q;
    o_weight_data0      = data_q[0];
    o_weight_data1      = data_q[1];
    o_weight_data2      = data_q[2];
    o_weight_data3      = data_q[3];
    o_weight_data4      = data_q[4];
    o_weight_data5      = data_q[5];
    o_weight_data6      = data_q[6];
    o_weight_data7      = data_q[7];
    o_cmd_weight_write  = cmd_w_q;
    o_cmd_Clauses_write = cmd_c_q;
    o_cmd_weight_read   = 1'b0;
    o_cmd_Clauses_read  = 1'b0;
    o_done              = done_q;
    o_error             = error_q;
    o_lines_written     = lines_written_q;
  end

endmodule
